// File: rtl/msk_timing_acq.sv
// Symbol-timing acquisition for the MSK demodulator: sweeps midpoint_adj, scores
// each offset against the known preamble, locks to the best one and tracks it.
module msk_timing_acq #(
    parameter int          ADJ_MIN     = -9,
    parameter int          ADJ_MAX     = 9,
    parameter int          PRE_LEN     = 16,
    parameter logic [30:0] PREAMBLE    = 31'h0000A5F0,
    parameter int          SETTLE_SYMS = 2,
    parameter int          DWELL_SYMS  = 64,
    parameter int          MATCH_THR   = 15,
    parameter int          LOSS_SYMS   = 256,
    localparam int         SC_W        = $clog2(PRE_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               data_in,
    input  logic               data_val_in,
    output logic signed [31:0] midpoint_adj,
    output logic               locked,
    output logic               frame_sync,
    output logic               sweep_fail,
    output logic [SC_W-1:0]    best_score,
    output logic [2:0]         state_o
);

    localparam int CNT_MAX = (SETTLE_SYMS > DWELL_SYMS) ? SETTLE_SYMS : DWELL_SYMS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LOSS_W  = $clog2(LOSS_SYMS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_DWELL  = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    localparam logic [PRE_LEN-1:0] PRE_BITS    = PREAMBLE[PRE_LEN-1:0];
    localparam logic [SC_W-1:0]    FILL_FULL   = SC_W'(PRE_LEN);
    localparam logic [SC_W-1:0]    FILL_LAST   = SC_W'(PRE_LEN - 1);
    localparam logic [SC_W-1:0]    THR         = SC_W'(MATCH_THR);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_SYMS - 1);
    localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL_SYMS - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_SYMS - 1);
    localparam logic signed [31:0] ADJ_LO      = 32'(ADJ_MIN);
    localparam logic signed [31:0] ADJ_HI      = 32'(ADJ_MAX);

    logic [2:0]          state_q, state_d;
    logic signed [31:0]  adj_q, adj_d;
    logic signed [31:0]  best_adj_q, best_adj_d;
    logic [PRE_LEN-1:0]  shreg_q, shreg_d;
    logic [SC_W-1:0]     fill_q, fill_d;
    logic [SC_W-1:0]     win_max_q, win_max_d;
    logic [SC_W-1:0]     best_score_q, best_score_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic                locked_q, locked_d;
    logic                frame_sync_q, frame_sync_d;
    logic                sweep_fail_q, sweep_fail_d;

    logic [PRE_LEN-1:0]  win;
    logic [SC_W-1:0]     score;
    logic [SC_W-1:0]     win_max_new;
    logic                score_ok;

    function automatic logic [SC_W-1:0] match_score(input logic [PRE_LEN-1:0] w);
        logic [PRE_LEN-1:0] agree;
        logic [SC_W-1:0]    n;
        agree = ~(w ^ PRE_BITS);
        n     = '0;
        for (int i = 0; i < PRE_LEN; i++) begin
            n = n + SC_W'(agree[i]);
        end
        return n;
    endfunction

    function automatic logic [SC_W-1:0] fill_inc(input logic [SC_W-1:0] f);
        return (f == FILL_FULL) ? f : f + SC_W'(1);
    endfunction

    // Score of the window including the bit arriving this cycle.
    always_comb begin
        win         = {shreg_q[PRE_LEN-2:0], data_in};
        score       = match_score(win);
        score_ok    = (fill_q >= FILL_LAST);
        win_max_new = (score_ok && (score > win_max_q)) ? score : win_max_q;
    end

    always_comb begin
        state_d      = state_q;
        adj_d        = adj_q;
        best_adj_d   = best_adj_q;
        shreg_d      = shreg_q;
        fill_d       = fill_q;
        win_max_d    = win_max_q;
        best_score_d = best_score_q;
        cnt_d        = cnt_q;
        loss_cnt_d   = loss_cnt_q;
        locked_d     = locked_q;
        frame_sync_d = 1'b0;
        sweep_fail_d = 1'b0;

        if (!enable) begin
            state_d    = S_IDLE;
            adj_d      = '0;
            fill_d     = '0;
            win_max_d  = '0;
            cnt_d      = '0;
            loss_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_SETTLE;
                    adj_d        = ADJ_LO;
                    best_adj_d   = ADJ_LO;
                    best_score_d = '0;
                    fill_d       = '0;
                    win_max_d    = '0;
                    cnt_d        = '0;
                end
                S_SETTLE: begin
                    if (data_val_in) begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_d   = '0;
                            state_d = S_DWELL;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DWELL: begin
                    if (data_val_in) begin
                        shreg_d   = win;
                        fill_d    = fill_inc(fill_q);
                        win_max_d = win_max_new;
                        if (cnt_q == DWELL_LAST) begin
                            cnt_d = '0;
                            // Strict compare: on a tie the earlier (lower) offset wins.
                            if (win_max_new > best_score_q) begin
                                best_score_d = win_max_new;
                                best_adj_d   = adj_q;
                            end
                            if (adj_q < ADJ_HI) begin
                                adj_d     = adj_q + 32'sd1;
                                fill_d    = '0;
                                win_max_d = '0;
                                state_d   = S_SETTLE;
                            end else begin
                                state_d = S_DECIDE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DECIDE: begin
                    if (best_score_q >= THR) begin
                        adj_d      = best_adj_q;
                        fill_d     = '0;
                        loss_cnt_d = '0;
                        locked_d   = 1'b1;
                        state_d    = S_LOCKED;
                    end else begin
                        sweep_fail_d = 1'b1;
                        adj_d        = ADJ_LO;
                        best_adj_d   = ADJ_LO;
                        best_score_d = '0;
                        fill_d       = '0;
                        win_max_d    = '0;
                        cnt_d        = '0;
                        state_d      = S_SETTLE;
                    end
                end
                S_LOCKED: begin
                    if (data_val_in) begin
                        shreg_d = win;
                        fill_d  = fill_inc(fill_q);
                        if (score_ok && (score >= THR)) begin
                            frame_sync_d = 1'b1;
                            loss_cnt_d   = '0;
                        end else if (loss_cnt_q == LOSS_LAST) begin
                            locked_d     = 1'b0;
                            adj_d        = ADJ_LO;
                            best_adj_d   = ADJ_LO;
                            best_score_d = '0;
                            fill_d       = '0;
                            win_max_d    = '0;
                            cnt_d        = '0;
                            loss_cnt_d   = '0;
                            state_d      = S_SETTLE;
                        end else begin
                            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            adj_q        <= '0;
            best_adj_q   <= '0;
            fill_q       <= '0;
            win_max_q    <= '0;
            best_score_q <= '0;
            cnt_q        <= '0;
            loss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            frame_sync_q <= 1'b0;
            sweep_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            adj_q        <= adj_d;
            best_adj_q   <= best_adj_d;
            fill_q       <= fill_d;
            win_max_q    <= win_max_d;
            best_score_q <= best_score_d;
            cnt_q        <= cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            locked_q     <= locked_d;
            frame_sync_q <= frame_sync_d;
            sweep_fail_q <= sweep_fail_d;
        end
    end

    // Shift register contents only matter once fill qualifies them.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign midpoint_adj = adj_q;
    assign locked       = locked_q;
    assign frame_sync   = frame_sync_q;
    assign sweep_fail   = sweep_fail_q;
    assign best_score   = best_score_q;
    assign state_o      = state_q;

endmodule

// File: doc/msk_timing_acq.md
# msk_timing_acq

Symbol-timing acquisition and tracking controller for the MSK demodulator. It sweeps the demodulator's `midpoint_adj` across a configured offset range. At each offset it scores the recovered bit stream against a known preamble, then locks to the best-scoring offset. After lock it monitors preamble recurrence and re-acquires on loss. It sits between the demodulator's `data_out`/`data_val` outputs and its `midpoint_adj` input, under control of the receive-path enable.

## Interface
- `ADJ_MIN`, -9: lowest `midpoint_adj` offset swept (signed).
- `ADJ_MAX`, 9: highest `midpoint_adj` offset swept; ADJ_MIN ≤ ADJ_MAX.
- `PRE_LEN`, 16: preamble length in bits (2..31).
- `PREAMBLE`, 16'hA5F0: preamble pattern. Bit PRE_LEN-1 is transmitted first.
- `SETTLE_SYMS`, 2: `data_val` strobes discarded after each offset change.
- `DWELL_SYMS`, 64: `data_val` strobes scored per offset.
- `MATCH_THR`, 15: minimum score (matching bits) to accept lock or count a match.
- `LOSS_SYMS`, 256: strobes without a match in LOCKED before declaring loss.
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run acquisition; low forces IDLE.
- `data_in`, in, 1: recovered bit from the demodulator.
- `data_val_in`, in, 1: bit strobe from the demodulator.
- `midpoint_adj`, out, 32 (int, signed): sample-point offset driven to the demodulator.
- `locked`, out, 1: high in LOCKED.
- `frame_sync`, out, 1: 1-cycle pulse on each preamble match (score ≥ MATCH_THR) while LOCKED.
- `sweep_fail`, out, 1: 1-cycle pulse when a full sweep ends with best score < MATCH_THR.
- `best_score`, out, $clog2(PRE_LEN+1): best score of the current or last sweep.
- `state_o`, out, 3: IDLE=0, SETTLE=1, DWELL=2, DECIDE=3, LOCKED=4.

## Operation
- **Window.** On each `data_val_in`, `win = {shreg[PRE_LEN-2:0], data_in}` and `shreg <= win`. The score is the popcount of `~(win ^ PREAMBLE)`, computed in the same cycle. A bit counter `fill` saturates at PRE_LEN. The score is valid only when `fill` reaches PRE_LEN including the current bit.
- **IDLE.** `midpoint_adj`=0 and all counters are cleared. On `enable`=1: set `midpoint_adj`=ADJ_MIN, clear `best_score`, set `best_adj`=ADJ_MIN, go to SETTLE.
- **SETTLE.** Clear `fill` and `win_max` on entry. After SETTLE_SYMS strobes, go to DWELL. The strobes consumed in SETTLE are not shifted.
- **DWELL.** Shift each strobe. `win_max` holds the maximum valid score. After DWELL_SYMS strobes:
  - If `win_max > best_score` (strictly greater), then `best_score <= win_max` and `best_adj <= midpoint_adj`. Ties keep the earlier, lower offset.
  - If `midpoint_adj` < ADJ_MAX, increment it and go to SETTLE.
  - Otherwise go to DECIDE.
- **DECIDE** (one cycle, using the final updated `best_score`):
  - If `best_score ≥ MATCH_THR`: `midpoint_adj <= best_adj`, clear `fill`, go to LOCKED.
  - Else: pulse `sweep_fail`, set `midpoint_adj`=ADJ_MIN, clear `best_score`, go to SETTLE.
- **LOCKED.**
  - Shift each strobe and increment `loss_cnt`.
  - A valid score ≥ MATCH_THR pulses `frame_sync` and clears `loss_cnt`.
  - When `loss_cnt` reaches LOSS_SYMS: deassert `locked`, set `midpoint_adj`=ADJ_MIN, clear `best_score`, go to SETTLE.
- **Enable.** `enable`=0 in any state goes to IDLE next cycle. This has priority over a simultaneous strobe.
- **No strobes.** When no strobes arrive, all states hold. There is no timeout on `data_val_in`.

## Timing
- **Reset values.** On `reset_n` low, asynchronously: `midpoint_adj`=0, `locked`=0, `frame_sync`=0, `sweep_fail`=0, `best_score`=0, `state_o`=IDLE.
- **Registered outputs.** All outputs are registered and change in the cycle after the triggering `data_val_in` edge.
  - `frame_sync` rises one cycle after the strobe that completes the match.
  - `locked` rises one cycle after DECIDE.
  - The new `midpoint_adj` appears one cycle after the last DWELL strobe, or one cycle after DECIDE.
- **Strobe rate.** Strobes may arrive on consecutive cycles; each one is counted.
- **Simultaneous events in DWELL.** If the last-strobe update and a score equal to the current `win_max` coincide, the current strobe's score is included in `win_max` before the best-score compare.
- **Sweep length.** One full sweep takes (ADJ_MAX-ADJ_MIN+1)·(SETTLE_SYMS+DWELL_SYMS) strobes plus one DECIDE cycle.
- **Reset mid-operation.** Reset returns the block to IDLE. It does not resume.

## Test plan
- **Lock at single peak.** A bench demod model emits the repeating PREAMBLE with 0 bit errors at adj=3, 1 error at adj 2 and 4, and random bits elsewhere. Defaults, `enable`=1 → after 19 offsets, DECIDE; `midpoint_adj`=3, `locked`=1, `best_score`=16; `frame_sync` pulses every 16 strobes.
- **Tie.** Error-free preamble at adj=-1 and adj=5 only → locks with `midpoint_adj`=-1.
- **No preamble.** All-zeros stream → `sweep_fail` pulses once per sweep; `midpoint_adj` returns to -9; `locked` stays 0.
- **Loss of lock.** Lock as in the first scenario, then stop sending the preamble → `locked` falls exactly 256 strobes after the last `frame_sync`, then `midpoint_adj`=-9 and a re-sweep reacquires adj=3.
- **Enable low mid-DWELL.** Drop `enable` at adj=0 → IDLE next cycle, `midpoint_adj`=0. Re-enabling restarts at -9 with `best_score`=0.
- **Async reset while LOCKED.** Pulse `reset_n` low between clock edges → all outputs take reset values immediately; the block stays in IDLE until `enable` is seen after release.
